// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    DEATH     = 3'd4,
    CLEAR     = 3'd5,
    GAME_OVER = 3'd6
  } game_state_t;

  localparam int DEF_READY_FRAMES  = 90;
  localparam int DEF_DEATH_FRAMES  = 60;
  localparam int DEF_CLEAR_FRAMES  = 60;
  localparam int DEF_INITIAL_LIVES = 3;
  localparam int DEF_MAX_LEVEL     = 15;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 4;

  // Largest of the three timed-state durations; sizes the frame counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter for the timed game states. Counts startOfFrame pulses and
// flags the terminal pulse, i.e. the one on which count == target-1.
module frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             startOfFrame,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = startOfFrame && (cnt == target - CNT_W'(1));

  // Count frames; restart on clear and after the terminal frame so the next timed state starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear || done) begin
      cnt <= '0;
    end else if (startOfFrame) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title / ready / play / pause / death / level
// clear / game over, with lives and level bookkeeping and the mover controls.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int READY_FRAMES  = DEF_READY_FRAMES,
  parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
  parameter int CLEAR_FRAMES  = DEF_CLEAR_FRAMES,
  parameter int INITIAL_LIVES = DEF_INITIAL_LIVES,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               pacman_hit,
  input  logic               dots_cleared,
  output logic               playGame,
  output logic               movers_resetN,
  output logic               maze_reload,
  output logic               score_clear,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output game_state_t        game_state
);

  localparam int CNT_W = $clog2(max3(READY_FRAMES, DEATH_FRAMES, CLEAR_FRAMES)) + 1;

  logic             start_prev;
  logic             pause_prev;
  logic             start_edge;
  logic             pause_edge;
  logic             timer_clear;
  logic             timer_done;
  logic [CNT_W-1:0] timer_target;

  assign start_edge = start_key && !start_prev;
  assign pause_edge = pause_key && !pause_prev;

  // Timed states are only ever entered from untimed states or through a
  // terminal frame, so holding the counter clear outside them guarantees
  // it starts from zero on every timed-state entry.
  assign timer_clear = !((game_state == READY) || (game_state == DEATH) ||
                         (game_state == CLEAR));

  // Select the duration of the current timed state.
  always_comb begin
    timer_target = '0;
    case (game_state)
      READY:   timer_target = CNT_W'(READY_FRAMES);
      DEATH:   timer_target = CNT_W'(DEATH_FRAMES);
      CLEAR:   timer_target = CNT_W'(CLEAR_FRAMES);
      default: timer_target = '0;
    endcase
  end

  frame_timer #(
    .CNT_W(CNT_W)
  ) u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .clear        (timer_clear),
    .startOfFrame (startOfFrame),
    .target       (timer_target),
    .done         (timer_done)
  );

  // Key edge detectors; previous values reset high so a key held through reset does not fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= start_key;
      pause_prev <= pause_key;
    end
  end

  // Game state machine with registered mover controls, strobes and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      game_state    <= IDLE;
      playGame      <= 1'b0;
      movers_resetN <= 1'b0;
      maze_reload   <= 1'b0;
      score_clear   <= 1'b0;
      lives         <= '0;
      level         <= '0;
    end else begin
      maze_reload <= 1'b0;
      score_clear <= 1'b0;
      case (game_state)
        IDLE: begin
          if (start_edge) begin
            game_state    <= READY;
            playGame      <= 1'b0;
            movers_resetN <= 1'b0;
            lives         <= LIVES_W'(INITIAL_LIVES);
            level         <= LEVEL_W'(1);
            maze_reload   <= 1'b1;
            score_clear   <= 1'b1;
          end
        end
        READY: begin
          if (timer_done) begin
            game_state    <= PLAY;
            playGame      <= 1'b1;
            movers_resetN <= 1'b1;
          end
        end
        PLAY: begin
          // A pause edge that loses to a hit or a clear is simply dropped.
          if (pacman_hit) begin
            game_state <= DEATH;
            playGame   <= 1'b0;
            lives      <= (lives == '0) ? '0 : lives - LIVES_W'(1);
          end else if (dots_cleared) begin
            game_state <= CLEAR;
            playGame   <= 1'b0;
          end else if (pause_edge) begin
            game_state <= PAUSE;
            playGame   <= 1'b0;
          end
        end
        PAUSE: begin
          // Movers stay out of reset so their positions freeze rather than restart.
          if (pause_edge) begin
            game_state <= PLAY;
            playGame   <= 1'b1;
          end
        end
        DEATH: begin
          if (timer_done) begin
            game_state    <= (lives == '0) ? GAME_OVER : READY;
            movers_resetN <= 1'b0;
          end
        end
        CLEAR: begin
          if (timer_done) begin
            game_state    <= READY;
            movers_resetN <= 1'b0;
            maze_reload   <= 1'b1;
            level         <= (level >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                            : level + LEVEL_W'(1);
          end
        end
        GAME_OVER: begin
          // Lives and level stay visible for the HUD until the next game.
          if (start_edge) begin
            game_state <= IDLE;
          end
        end
        default: begin
          game_state    <= IDLE;
          playGame      <= 1'b0;
          movers_resetN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short frame durations.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               start_key = 1'b0;
  logic               pause_key = 1'b0;
  logic               pacman_hit = 1'b0;
  logic               dots_cleared = 1'b0;
  logic               playGame;
  logic               movers_resetN;
  logic               maze_reload;
  logic               score_clear;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  game_state_t        game_state;

  int total = 0;
  int bad   = 0;

  game_flow_ctrl #(
    .READY_FRAMES (3),
    .DEATH_FRAMES (2),
    .CLEAR_FRAMES (2),
    .INITIAL_LIVES(3),
    .MAX_LEVEL    (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .start_key    (start_key),
    .pause_key    (pause_key),
    .pacman_hit   (pacman_hit),
    .dots_cleared (dots_cleared),
    .playGame     (playGame),
    .movers_resetN(movers_resetN),
    .maze_reload  (maze_reload),
    .score_clear  (score_clear),
    .lives        (lives),
    .level        (level),
    .game_state   (game_state)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic press_start();
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    tick();
  endtask

  // From IDLE: new game, then the full ready period into PLAY.
  task automatic go_to_play();
    press_start();
    repeat (3) frame();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_key = 1'b1;
    repeat (3) tick();
    total++; if (game_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", game_state, IDLE); end
    total++; if (playGame !== 1'b0 || movers_resetN !== 1'b0) begin bad++; $display("FAIL reset_movers got=%b%b want=00", playGame, movers_resetN); end
    total++; if (maze_reload !== 1'b0 || score_clear !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", maze_reload, score_clear); end
    total++; if (lives !== 2'd0 || level !== 4'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", lives, level); end
    reset = 1'b0;
    repeat (3) tick();
    total++; if (game_state !== IDLE) begin bad++; $display("FAIL start_held_through_reset got=%0d want=%0d", game_state, IDLE); end
    start_key = 1'b0;
    tick();
  endtask

  task automatic test_start();
    start_key = 1'b1;
    tick();
    total++; if (game_state !== READY) begin bad++; $display("FAIL start_state got=%0d want=%0d", game_state, READY); end
    total++; if (lives !== 2'd3 || level !== 4'd1) begin bad++; $display("FAIL start_counters got=%0d/%0d want=3/1", lives, level); end
    total++; if (maze_reload !== 1'b1 || score_clear !== 1'b1) begin bad++; $display("FAIL start_strobes got=%b%b want=11", maze_reload, score_clear); end
    tick();
    total++; if (maze_reload !== 1'b0 || score_clear !== 1'b0) begin bad++; $display("FAIL start_strobes_once got=%b%b want=00", maze_reload, score_clear); end
    start_key = 1'b0;
    frame();
    frame();
    total++; if (game_state !== READY || playGame !== 1'b0 || movers_resetN !== 1'b0) begin bad++; $display("FAIL ready_hold got=%0d/%b%b want=%0d/00", game_state, playGame, movers_resetN, READY); end
    frame();
    total++; if (game_state !== PLAY || playGame !== 1'b1 || movers_resetN !== 1'b1) begin bad++; $display("FAIL ready_to_play got=%0d/%b%b want=%0d/11", game_state, playGame, movers_resetN, PLAY); end
  endtask

  task automatic test_death();
    logic [LIVES_W-1:0] exp_lives;
    exp_lives = 2'd3;
    for (int i = 0; i < 3; i++) begin
      pacman_hit = 1'b1;
      tick();
      pacman_hit = 1'b0;
      exp_lives = exp_lives - 2'd1;
      total++; if (game_state !== DEATH || lives !== exp_lives) begin bad++; $display("FAIL death_entry%0d got=%0d/%0d want=%0d/%0d", i, game_state, lives, DEATH, exp_lives); end
      total++; if (playGame !== 1'b0 || movers_resetN !== 1'b1) begin bad++; $display("FAIL death_movers%0d got=%b%b want=01", i, playGame, movers_resetN); end
      frame();
      frame();
      if (i < 2) begin
        total++; if (game_state !== READY || movers_resetN !== 1'b0) begin bad++; $display("FAIL death_to_ready%0d got=%0d/%b want=%0d/0", i, game_state, movers_resetN, READY); end
        repeat (3) frame();
      end
    end
    total++; if (game_state !== GAME_OVER || lives !== 2'd0 || level !== 4'd1) begin bad++; $display("FAIL game_over got=%0d/%0d/%0d want=%0d/0/1", game_state, lives, level, GAME_OVER); end
    total++; if (playGame !== 1'b0 || movers_resetN !== 1'b0) begin bad++; $display("FAIL game_over_movers got=%b%b want=00", playGame, movers_resetN); end
    press_start();
    total++; if (game_state !== IDLE) begin bad++; $display("FAIL game_over_to_idle got=%0d want=%0d", game_state, IDLE); end
  endtask

  task automatic test_coincide();
    go_to_play();
    pacman_hit = 1'b1;
    dots_cleared = 1'b1;
    tick();
    pacman_hit = 1'b0;
    dots_cleared = 1'b0;
    total++; if (game_state !== DEATH || lives !== 2'd2 || level !== 4'd1) begin bad++; $display("FAIL coincide_priority got=%0d/%0d/%0d want=%0d/2/1", game_state, lives, level, DEATH); end
    total++; if (maze_reload !== 1'b0) begin bad++; $display("FAIL coincide_reload got=%b want=0", maze_reload); end
    frame();
    frame();
    total++; if (game_state !== READY || level !== 4'd1 || maze_reload !== 1'b0) begin bad++; $display("FAIL coincide_exit got=%0d/%0d/%b want=%0d/1/0", game_state, level, maze_reload, READY); end
    repeat (3) frame();
  endtask

  task automatic test_clear();
    dots_cleared = 1'b1;
    tick();
    dots_cleared = 1'b0;
    total++; if (game_state !== CLEAR || playGame !== 1'b0) begin bad++; $display("FAIL clear_entry got=%0d/%b want=%0d/0", game_state, playGame, CLEAR); end
    frame();
    total++; if (game_state !== CLEAR || maze_reload !== 1'b0) begin bad++; $display("FAIL clear_hold got=%0d/%b want=%0d/0", game_state, maze_reload, CLEAR); end
    frame();
    total++; if (game_state !== READY || level !== 4'd2 || maze_reload !== 1'b1) begin bad++; $display("FAIL clear_exit got=%0d/%0d/%b want=%0d/2/1", game_state, level, maze_reload, READY); end
    tick();
    total++; if (maze_reload !== 1'b0) begin bad++; $display("FAIL clear_reload_once got=%b want=0", maze_reload); end
    repeat (3) frame();
    // Climb from level 2 to 15, then one more clear must saturate.
    for (int i = 0; i < 14; i++) begin
      dots_cleared = 1'b1;
      tick();
      dots_cleared = 1'b0;
      frame();
      frame();
      if (i == 12) begin
        total++; if (level !== 4'd15) begin bad++; $display("FAIL level_reach_max got=%0d want=15", level); end
      end
      repeat (3) frame();
    end
    total++; if (level !== 4'd15 || game_state !== PLAY) begin bad++; $display("FAIL level_saturate got=%0d/%0d want=15/%0d", level, game_state, PLAY); end
  endtask

  task automatic test_pause();
    pause_key = 1'b1;
    repeat (10) tick();
    total++; if (game_state !== PAUSE || playGame !== 1'b0 || movers_resetN !== 1'b1) begin bad++; $display("FAIL pause_held got=%0d/%b%b want=%0d/01", game_state, playGame, movers_resetN, PAUSE); end
    pacman_hit = 1'b1;
    dots_cleared = 1'b1;
    frame();
    frame();
    pacman_hit = 1'b0;
    dots_cleared = 1'b0;
    total++; if (game_state !== PAUSE || lives !== 2'd2 || level !== 4'd15) begin bad++; $display("FAIL pause_ignores got=%0d/%0d/%0d want=%0d/2/15", game_state, lives, level, PAUSE); end
    pause_key = 1'b0;
    tick();
    pause_key = 1'b1;
    tick();
    pause_key = 1'b0;
    total++; if (game_state !== PLAY || playGame !== 1'b1) begin bad++; $display("FAIL pause_resume got=%0d/%b want=%0d/1", game_state, playGame, PLAY); end
    tick();
  endtask

  task automatic test_reset_in_death();
    pacman_hit = 1'b1;
    tick();
    pacman_hit = 1'b0;
    total++; if (game_state !== DEATH || lives !== 2'd1) begin bad++; $display("FAIL pre_reset_death got=%0d/%0d want=%0d/1", game_state, lives, DEATH); end
    reset = 1'b1;
    tick();
    total++; if (game_state !== IDLE || lives !== 2'd0 || level !== 4'd0) begin bad++; $display("FAIL reset_in_death got=%0d/%0d/%0d want=%0d/0/0", game_state, lives, level, IDLE); end
    total++; if (playGame !== 1'b0 || movers_resetN !== 1'b0 || maze_reload !== 1'b0 || score_clear !== 1'b0) begin bad++; $display("FAIL reset_in_death_outputs got=%b%b%b%b want=0000", playGame, movers_resetN, maze_reload, score_clear); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_death();
    test_coincide();
    test_clear();
    test_pause();
    test_reset_in_death();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
